// File: rtl/chan_dump.sv
// Dumps one channel's circular sample RAM, oldest to newest, one byte at a time over a
// trmt/tx_done UART handshake, and pulses dump_done when every entry has been sent.
module chan_dump #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_start,
  input  logic [2:0]      dump_chan,
  input  logic [LOG2-1:0] waddr_last,
  input  logic [7:0]      rdata,
  input  logic            tx_done,
  output logic [2:0]      ch_sel,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            busy,
  output logic            dump_done
);

  localparam logic [LOG2:0]   DEPTH = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2-1:0] LAST  = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] ONE   = LOG2'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LOAD    = 3'd2,
    XMIT    = 3'd3,
    WAIT_TX = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      ch_sel_reg, ch_sel_next;
  logic [LOG2-1:0] raddr_reg, raddr_next;
  logic [7:0]      tx_data_reg, tx_data_next;
  logic            trmt_reg, trmt_next;
  logic            busy_reg, busy_next;
  logic            dump_done_reg, dump_done_next;
  logic [LOG2-1:0] count_reg, count_next;
  logic            settle_reg, settle_next;

  logic            chan_ok;
  logic [LOG2-1:0] start_addr;
  logic [LOG2-1:0] raddr_inc;
  logic            last_byte;

  assign chan_ok    = (dump_chan != 3'd0) && (dump_chan <= 3'd5);
  assign start_addr = ({1'b0, waddr_last} >= DEPTH) ? '0 : waddr_last;
  assign raddr_inc  = (raddr_reg == LAST) ? '0 : raddr_reg + ONE;
  assign last_byte  = (count_reg == LAST);

  // State and every output are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ch_sel_reg    <= '0;
      raddr_reg     <= '0;
      tx_data_reg   <= '0;
      trmt_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      dump_done_reg <= 1'b0;
      count_reg     <= '0;
      settle_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ch_sel_reg    <= ch_sel_next;
      raddr_reg     <= raddr_next;
      tx_data_reg   <= tx_data_next;
      trmt_reg      <= trmt_next;
      busy_reg      <= busy_next;
      dump_done_reg <= dump_done_next;
      count_reg     <= count_next;
      settle_reg    <= settle_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (dump_start && chan_ok) state_next = READ;
      // After an address step READ lasts one extra cycle, giving four cycles tx_done->trmt.
      READ:    if (!settle_reg) state_next = LOAD;
      LOAD:    state_next = XMIT;
      XMIT:    state_next = WAIT_TX;
      WAIT_TX: if (tx_done) state_next = last_byte ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ch_sel_next    = ch_sel_reg;
    raddr_next     = raddr_reg;
    tx_data_next   = tx_data_reg;
    trmt_next      = 1'b0;
    busy_next      = busy_reg;
    dump_done_next = 1'b0;
    count_next     = count_reg;
    settle_next    = settle_reg;
    case (state_reg)
      IDLE: begin
        if (dump_start) begin
          if (chan_ok) begin
            ch_sel_next = dump_chan;
            raddr_next  = start_addr;
            count_next  = '0;
            busy_next   = 1'b1;
            settle_next = 1'b0;
          end else begin
            dump_done_next = 1'b1;
          end
        end
      end
      READ: settle_next = 1'b0;
      LOAD: begin
        tx_data_next = rdata;
        trmt_next    = 1'b1;
      end
      WAIT_TX: begin
        if (tx_done) begin
          if (last_byte) begin
            busy_next      = 1'b0;
            dump_done_next = 1'b1;
          end else begin
            count_next  = count_reg + ONE;
            raddr_next  = raddr_inc;
            settle_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign ch_sel    = ch_sel_reg;
  assign raddr     = raddr_reg;
  assign tx_data   = tx_data_reg;
  assign trmt      = trmt_reg;
  assign busy      = busy_reg;
  assign dump_done = dump_done_reg;

endmodule

// File: tb/tb_chan_dump.sv
// Bench for chan_dump: RAM and UART models, table of dump cases checked against a
// queue-based reference, plus latency, injection and mid-dump reset sequences.
module tb_chan_dump;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            dump_start;
  logic [2:0]      dump_chan;
  logic [LOG2-1:0] waddr_last;
  logic [7:0]      rdata;
  logic            tx_done;
  logic [2:0]      ch_sel;
  logic [LOG2-1:0] raddr;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            busy;
  logic            dump_done;

  logic            uart_done;
  logic            stray_done;
  int              tx_delay;
  int              countdown;
  int              cyc;
  int              passed;
  int              total;

  logic [7:0] mem [0:7][0:ENTRIES-1];

  assign tx_done = uart_done | stray_done;

  chan_dump #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_chan  (dump_chan),
    .waddr_last (waddr_last),
    .rdata      (rdata),
    .tx_done    (tx_done),
    .ch_sel     (ch_sel),
    .raddr      (raddr),
    .tx_data    (tx_data),
    .trmt       (trmt),
    .busy       (busy),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Synchronous-read RAM bank selected by ch_sel.
  always @(posedge clk) rdata <= mem[ch_sel][raddr];

  // UART: tx_done pulse tx_delay cycles after each trmt.
  initial begin
    uart_done = 1'b0;
    countdown = 0;
  end
  always @(negedge clk) begin
    uart_done = 1'b0;
    if (!rst_n) begin
      countdown = 0;
    end else begin
      if (countdown > 0) begin
        countdown = countdown - 1;
        if (countdown == 0) uart_done = 1'b1;
      end
      if (trmt) countdown = tx_delay;
    end
  end

  typedef struct {
    logic [2:0]      ch;
    logic [LOG2-1:0] wl;
    int              dly;
    bit              inject;
    int              exp_n;
    int              exp_first;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    total = total + 1;
    if (act == exp) passed = passed + 1;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_dump(input vec_t v);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int  start, budget, done_at, gaps, chsel_bad, multi, bad, quiet;
    bit  valid, done;
    logic prev_trmt;
    valid = (v.ch >= 3'd1) && (v.ch <= 3'd5);
    start = (int'(v.wl) >= ENTRIES) ? 0 : int'(v.wl);
    if (valid)
      for (int k = 0; k < ENTRIES; k++) exp_q.push_back(mem[v.ch][(start + k) % ENTRIES]);
    tx_delay = v.dly;
    budget   = ENTRIES * (v.dly + 8) + 100;

    @(negedge clk);
    dump_start = 1'b1; dump_chan = v.ch; waddr_last = v.wl;
    @(negedge clk);
    dump_start = 1'b0;
    dump_chan  = 3'($urandom_range(7, 0));
    waddr_last = LOG2'($urandom_range(511, 0));
    if (valid) check("first_raddr", raddr, v.exp_first);

    done = 0; done_at = -1; gaps = 0; chsel_bad = 0; multi = 0; prev_trmt = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      stray_done = 1'b0;
      dump_start = 1'b0;
      if (trmt) begin
        got_q.push_back(tx_data);
        if (ch_sel != v.ch) chsel_bad++;
        if (v.inject && (got_q.size() % 7 == 3)) stray_done = 1'b1;
        if (v.inject && (got_q.size() % 50 == 10)) begin
          dump_start = 1'b1;
          dump_chan  = 3'd5;
        end
      end
      if (trmt && prev_trmt) multi++;
      prev_trmt = trmt;
      if (dump_done) begin
        done = 1; done_at = c;
        if (busy) gaps++;
      end else if (busy != valid) begin
        gaps++;
      end
      if (!done) @(negedge clk);
    end
    stray_done = 1'b0;
    dump_start = 1'b0;

    check("done_seen", done, 1);
    check("byte_count", got_q.size(), v.exp_n);
    bad = 0;
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      if (got_q[k] != exp_q[k]) bad++;
    check("byte_order_errs", bad, 0);
    check("ch_sel_hold", chsel_bad, 0);
    check("trmt_width", multi, 0);
    check("busy_window", gaps, 0);
    if (!valid) check("bad_chan_done_lat", done_at, 0);
    @(negedge clk);
    check("done_pulse_width", dump_done, 0);
    check("busy_after_done", busy, 0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trmt || dump_done || busy) quiet++;
    end
    check("quiet_after", quiet, 0);
    $display("dump ch=%0d waddr=%0d delay=%0d inject=%0d bytes=%0d errs=%0d",
             v.ch, v.wl, v.dly, v.inject, got_q.size(), bad);
  endtask

  task automatic latency_check();
    int t0, rel, first, second;
    logic [LOG2-1:0] ra1, ra20, ra21;
    tx_delay = 17; first = -1; second = -1;
    ra1 = '0; ra20 = '0; ra21 = '0;
    @(negedge clk);
    dump_start = 1'b1; dump_chan = 3'd4; waddr_last = 9'd50; t0 = cyc;
    @(negedge clk);
    dump_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rel = cyc - t0;
      if (rel == 1)  ra1  = raddr;
      if (rel == 20) ra20 = raddr;
      if (rel == 21) ra21 = raddr;
      if (trmt) begin
        if (first < 0) first = rel;
        else if (second < 0) second = rel;
      end
      @(negedge clk);
    end
    check("lat_raddr_c1", ra1, 50);
    check("lat_trmt_first", first, 3);
    check("lat_raddr_c20", ra20, 50);
    check("lat_raddr_c21", ra21, 51);
    check("lat_trmt_second", second, 24);
    $display("latency: raddr@1=%0d trmt@%0d raddr@21=%0d trmt@%0d", ra1, first, ra21, second);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reset_mid_dump();
    int n, stray;
    vec_t v;
    tx_delay = 2; n = 0;
    @(negedge clk);
    dump_start = 1'b1; dump_chan = 3'd1; waddr_last = 9'd0;
    @(negedge clk);
    dump_start = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (trmt) n++;
      if (n == 100 && trmt) break;
      @(negedge clk);
    end
    check("bytes_before_reset", n, 100);
    #2 rst_n = 1'b0;
    #1;
    check("reset_trmt_async", trmt, 0);
    check("reset_busy_async", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dump_done || trmt || busy) stray++;
    end
    check("no_done_after_abort", stray, 0);
    $display("reset mid-dump after %0d bytes, post-reset activity=%0d", n, stray);
    v = '{3'd4, 9'd200, 3, 1'b0, ENTRIES, 200};
    run_dump(v);
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; dump_start = 1'b0; dump_chan = 3'd0; waddr_last = '0;
    stray_done = 1'b0; tx_delay = 10;
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < ENTRIES; i++)
        mem[c][i] = (c == 1) ? 8'(i) : 8'($urandom_range(255, 0));

    vecs[0] = '{3'd1, 9'd0,   10, 1'b0, ENTRIES, 0};
    vecs[1] = '{3'd3, 9'd380, 3,  1'b0, ENTRIES, 380};
    vecs[2] = '{3'd0, 9'd5,   2,  1'b0, 0,       0};
    vecs[3] = '{3'd7, 9'd5,   2,  1'b0, 0,       0};
    vecs[4] = '{3'd6, 9'd100, 2,  1'b0, 0,       0};
    vecs[5] = '{3'd5, 9'd400, 1,  1'b0, ENTRIES, 0};
    vecs[6] = '{3'd2, 9'd383, 2,  1'b1, ENTRIES, 383};

    repeat (3) @(negedge clk);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_raddr", raddr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_trmt", trmt, 0);
    check("rst_busy", busy, 0);
    check("rst_dump_done", dump_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_dump(vecs[i]);
    latency_check();
    reset_mid_dump();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
